// File: rtl/alu_defs_pkg.sv
// Fixed encodings shared by the ALU control path: ALU operation codes,
// decoder class codes and the funct7 patterns the ALU decoder recognises.
package alu_defs_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;
  localparam logic [4:0] ALU_CLZ    = 5'd18;
  localparam logic [4:0] ALU_CTZ    = 5'd19;
  localparam logic [4:0] ALU_CPOP   = 5'd20;
  localparam logic [4:0] ALU_SEXTB  = 5'd21;
  localparam logic [4:0] ALU_SEXTH  = 5'd22;
  localparam logic [4:0] ALU_ZEXTH  = 5'd23;
  localparam logic [4:0] ALU_ROL    = 5'd24;
  localparam logic [4:0] ALU_ROR    = 5'd25;
  localparam logic [4:0] ALU_ORCB   = 5'd26;
  localparam logic [4:0] ALU_REV8   = 5'd27;
  localparam logic [4:0] ALU_MIN    = 5'd28;
  localparam logic [4:0] ALU_MAX    = 5'd29;
  localparam logic [4:0] ALU_MINU   = 5'd30;
  localparam logic [4:0] ALU_MAXU   = 5'd31;

  localparam logic [1:0] ALU_CLS_MEM    = 2'b00;
  localparam logic [1:0] ALU_CLS_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CLS_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_CLS_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_MINMAX = 7'b0000101;
  localparam logic [6:0] F7_ROT    = 7'b0110000;
  localparam logic [6:0] F7_ZEXT   = 7'b0000100;
  localparam logic [6:0] F7_ORCB   = 7'b0010100;
  localparam logic [6:0] F7_REV8   = 7'b0110100;

  // Operand-B inversion, used only by andn/orn/xnor.
  localparam logic [1:0] INV_NONE = 2'b00;
  localparam logic [1:0] INV_B    = 2'b01;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps ALU class, funct3/funct7 and rs2 to a registered
// ALU operation code and operand-inversion mask (one cycle latency).
module alu_decoder
  import alu_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] alu_2bit_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rs_2,
  output logic [1:0] invert_inputs,
  output logic [4:0] alu_op
);

  logic [4:0] alu_op_d, alu_op_q;
  logic [1:0] invert_d, invert_q;

  always_comb begin
    alu_op_d = ALU_ADD;
    invert_d = INV_NONE;
    unique case (alu_2bit_op)
      ALU_CLS_MEM:    alu_op_d = ALU_ADD;
      ALU_CLS_BRANCH: alu_op_d = ALU_SUB;
      ALU_CLS_RTYPE: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  alu_op_d = ALU_ADD;
              3'b001:  alu_op_d = ALU_SLL;
              3'b010:  alu_op_d = ALU_SLT;
              3'b011:  alu_op_d = ALU_SLTU;
              3'b100:  alu_op_d = ALU_XOR;
              3'b101:  alu_op_d = ALU_SRL;
              3'b110:  alu_op_d = ALU_OR;
              default: alu_op_d = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              3'b000: alu_op_d = ALU_SUB;
              3'b101: alu_op_d = ALU_SRA;
              3'b100: begin alu_op_d = ALU_XOR; invert_d = INV_B; end
              3'b110: begin alu_op_d = ALU_OR;  invert_d = INV_B; end
              3'b111: begin alu_op_d = ALU_AND; invert_d = INV_B; end
              default: alu_op_d = ALU_ADD;
            endcase
          end
          F7_MULDIV: begin
            case (funct3)
              3'b000:  alu_op_d = ALU_MUL;
              3'b001:  alu_op_d = ALU_MULH;
              3'b010:  alu_op_d = ALU_MULHSU;
              3'b011:  alu_op_d = ALU_MULHU;
              3'b100:  alu_op_d = ALU_DIV;
              3'b101:  alu_op_d = ALU_DIVU;
              3'b110:  alu_op_d = ALU_REM;
              default: alu_op_d = ALU_REMU;
            endcase
          end
          F7_MINMAX: begin
            case (funct3)
              3'b100:  alu_op_d = ALU_MIN;
              3'b101:  alu_op_d = ALU_MINU;
              3'b110:  alu_op_d = ALU_MAX;
              3'b111:  alu_op_d = ALU_MAXU;
              default: alu_op_d = ALU_ADD;
            endcase
          end
          F7_ROT: begin
            case (funct3)
              3'b001:  alu_op_d = ALU_ROL;
              3'b101:  alu_op_d = ALU_ROR;
              default: alu_op_d = ALU_ADD;
            endcase
          end
          F7_ZEXT: begin
            if (funct3 == 3'b100 && rs_2 == 5'b00000) alu_op_d = ALU_ZEXTH;
          end
          default: alu_op_d = ALU_ADD;
        endcase
      end
      ALU_CLS_ITYPE: begin
        case (funct3)
          3'b000: alu_op_d = ALU_ADD;
          3'b010: alu_op_d = ALU_SLT;
          3'b011: alu_op_d = ALU_SLTU;
          3'b100: alu_op_d = ALU_XOR;
          3'b110: alu_op_d = ALU_OR;
          3'b111: alu_op_d = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) begin
              alu_op_d = ALU_SLL;
            end else if (funct7 == F7_ROT) begin
              // Zbb unary ops share the rotate funct7 and are selected by rs2.
              case (rs_2)
                5'b00000: alu_op_d = ALU_CLZ;
                5'b00001: alu_op_d = ALU_CTZ;
                5'b00010: alu_op_d = ALU_CPOP;
                5'b00100: alu_op_d = ALU_SEXTB;
                5'b00101: alu_op_d = ALU_SEXTH;
                default:  alu_op_d = ALU_ADD;
              endcase
            end
          end
          default: begin
            if (funct7 == F7_BASE) begin
              alu_op_d = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              alu_op_d = ALU_SRA;
            end else if (funct7 == F7_ROT) begin
              alu_op_d = ALU_ROR;
            end else if (funct7 == F7_ORCB && rs_2 == 5'b00111) begin
              alu_op_d = ALU_ORCB;
            end else if (funct7 == F7_REV8 && rs_2 == 5'b11000) begin
              alu_op_d = ALU_REV8;
            end
          end
        endcase
      end
      default: alu_op_d = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op_q <= ALU_ADD;
      invert_q <= INV_NONE;
    end else begin
      alu_op_q <= alu_op_d;
      invert_q <= invert_d;
    end
  end

  assign alu_op        = alu_op_q;
  assign invert_inputs = invert_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases plus randomized decode
// compared against a table-driven reference model.
module tb_alu_decoder;

  // Operation numbering follows the listed order of the ALU operations.
  typedef enum int {
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU,
    M_CLZ, M_CTZ, M_CPOP, M_SEXTB, M_SEXTH, M_ZEXTH, M_ROL, M_ROR, M_ORCB, M_REV8,
    M_MIN, M_MAX, M_MINU, M_MAXU
  } op_e;

  logic       clk;
  logic       rst_n;
  logic [1:0] alu_2bit_op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs_2;
  logic [1:0] invert_inputs;
  logic [4:0] alu_op;

  int n_tests;
  int n_fail;

  alu_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_2bit_op  (alu_2bit_op),
    .funct3       (funct3),
    .funct7       (funct7),
    .rs_2         (rs_2),
    .invert_inputs(invert_inputs),
    .alu_op       (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got inv=%b op=%0d, expected inv=%b op=%0d",
               tag, got[6:5], got[4:0], exp[6:5], exp[4:0]);
    end
  endtask

  function automatic logic [6:0] pack(input op_e op, input logic [1:0] inv);
    logic [4:0] o;
    o = 5'(int'(op));
    return {inv, o};
  endfunction

  // Reference decode, written as lookup tables over the documented encodings.
  function automatic logic [6:0] ref_decode(input logic rst_ok, input logic [1:0] cls,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rs2);
    op_e base_tbl[8];
    op_e mm_tbl[4];
    op_e un_tbl[8];
    op_e op;
    logic [1:0] inv;
    base_tbl = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
    mm_tbl   = '{M_MIN, M_MINU, M_MAX, M_MAXU};
    un_tbl   = '{M_CLZ, M_CTZ, M_CPOP, M_ADD, M_SEXTB, M_SEXTH, M_ADD, M_ADD};
    op  = M_ADD;
    inv = 2'b00;
    if (!rst_ok) return pack(M_ADD, 2'b00);
    if (cls == 2'd1) op = M_SUB;
    else if (cls == 2'd2) begin
      if (f7 == 7'd0) op = base_tbl[f3];
      else if (f7 == 7'h20) begin
        if (f3 == 3'd0) op = M_SUB;
        else if (f3 == 3'd5) op = M_SRA;
        else if (f3 == 3'd4 || f3 >= 3'd6) begin
          op  = base_tbl[f3];
          inv = 2'b01;
        end
      end
      else if (f7 == 7'd1) op = op_e'(int'(M_MUL) + int'(f3));
      else if (f7 == 7'd5 && f3 >= 3'd4) op = mm_tbl[f3 - 3'd4];
      else if (f7 == 7'h30 && f3 == 3'd1) op = M_ROL;
      else if (f7 == 7'h30 && f3 == 3'd5) op = M_ROR;
      else if (f7 == 7'd4 && f3 == 3'd4 && rs2 == 5'd0) op = M_ZEXTH;
    end else if (cls == 2'd3) begin
      if (f3 != 3'd1 && f3 != 3'd5) op = base_tbl[f3];
      else if (f3 == 3'd1) begin
        if (f7 == 7'd0) op = M_SLL;
        else if (f7 == 7'h30 && rs2 < 5'd8) op = un_tbl[rs2[2:0]];
      end else begin
        if (f7 == 7'd0) op = M_SRL;
        else if (f7 == 7'h20) op = M_SRA;
        else if (f7 == 7'h30) op = M_ROR;
        else if (f7 == 7'h14 && rs2 == 5'd7) op = M_ORCB;
        else if (f7 == 7'h34 && rs2 == 5'd24) op = M_REV8;
      end
    end
    return pack(op, inv);
  endfunction

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive(input logic r, input logic [1:0] cls, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rs2);
    @(negedge clk);
    rst_n       = r;
    alu_2bit_op = cls;
    funct3      = f3;
    funct7      = f7;
    rs_2        = rs2;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [1:0] cls, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rs2, input op_e exp_op,
                          input logic [1:0] exp_inv);
    drive(1'b1, cls, f3, f7, rs2);
    check_eq(tag, {invert_inputs, alu_op}, pack(exp_op, exp_inv));
  endtask

  logic [6:0] f7_pool[10];
  logic [4:0] rs2_pool[8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; alu_2bit_op = 2'b10; funct3 = 3'd0; funct7 = 7'h20; rs_2 = 5'd0;

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b10, 3'b111, 7'h20, 5'($urandom));
      check_eq("reset", {invert_inputs, alu_op}, 7'd0);
    end

    directed("addi",  2'b11, 3'b000, 7'h00, 5'b00011, M_ADD,  2'b00);
    directed("ror",   2'b10, 3'b101, 7'h30, 5'b00011, M_ROR,  2'b00);
    directed("clz",   2'b11, 3'b001, 7'h30, 5'b00000, M_CLZ,  2'b00);
    directed("cpop",  2'b11, 3'b001, 7'h30, 5'b00010, M_CPOP, 2'b00);
    directed("andn",  2'b10, 3'b111, 7'h20, 5'b00101, M_AND,  2'b01);
    directed("sub",   2'b10, 3'b000, 7'h20, 5'b00101, M_SUB,  2'b00);
    for (int f = 0; f < 8; f++)
      directed("muldiv", 2'b10, 3'(f), 7'h01, 5'd9, op_e'(int'(M_MUL) + f), 2'b00);
    directed("branch", 2'b01, 3'b111, 7'h20, 5'd3, M_SUB, 2'b00);
    directed("bad_f7", 2'b10, 3'b111, 7'h7f, 5'd3, M_ADD, 2'b00);
    directed("orcb",  2'b11, 3'b101, 7'h14, 5'b00111, M_ORCB, 2'b00);
    directed("rev8",  2'b11, 3'b101, 7'h34, 5'b11000, M_REV8, 2'b00);
    directed("zexth", 2'b10, 3'b100, 7'h04, 5'b00000, M_ZEXTH, 2'b00);
    directed("maxu",  2'b10, 3'b111, 7'h05, 5'd1, M_MAXU, 2'b00);

    f7_pool  = '{7'h00, 7'h20, 7'h01, 7'h05, 7'h30, 7'h04, 7'h14, 7'h34, 7'h7f, 7'h00};
    rs2_pool = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd7, 5'd24, 5'd0};
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [1:0] cls;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] rs2;
      r   = ($urandom_range(0, 19) != 0);
      cls = 2'($urandom);
      f3  = 3'($urandom);
      f7  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : f7_pool[$urandom_range(0, 8)];
      rs2 = ($urandom_range(0, 7) == 7) ? 5'($urandom) : rs2_pool[$urandom_range(0, 6)];
      drive(r, cls, f3, f7, rs2);
      check_eq("random", {invert_inputs, alu_op}, ref_decode(r, cls, f3, f7, rs2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
